// File: rtl/shift_pkg.sv
// Shared encodings for the shift command sequencer and the registered shifter it drives.
package shift_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SH_MAX_STEP = 3;
  localparam int unsigned SH_OP_W     = 3;
  localparam int unsigned SHAMT_W     = 2;
  localparam int unsigned CMD_OP_W    = 2;
  localparam int unsigned AMT_W       = 3;
  localparam int unsigned STATE_W     = 2;

  // Shifter op encodings
  localparam logic [SH_OP_W-1:0] SH_NOP  = 3'b000;
  localparam logic [SH_OP_W-1:0] SH_LOAD = 3'b001;
  localparam logic [SH_OP_W-1:0] SH_LSL  = 3'b010;
  localparam logic [SH_OP_W-1:0] SH_LSR  = 3'b011;
  localparam logic [SH_OP_W-1:0] SH_ASR  = 3'b100;

  // Command op encodings
  localparam logic [CMD_OP_W-1:0] CMD_LSL = 2'b00;
  localparam logic [CMD_OP_W-1:0] CMD_LSR = 2'b01;
  localparam logic [CMD_OP_W-1:0] CMD_ASR = 2'b10;
  localparam logic [CMD_OP_W-1:0] CMD_RSV = 2'b11;

  // Sequencer states
  localparam logic [STATE_W-1:0] S_IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] S_LOAD  = 2'b01;
  localparam logic [STATE_W-1:0] S_SHIFT = 2'b10;
  localparam logic [STATE_W-1:0] S_RESP  = 2'b11;

  // Command kind to shifter op; reserved maps to NOP
  function automatic logic [SH_OP_W-1:0] map_op(input logic [CMD_OP_W-1:0] op);
    logic [SH_OP_W-1:0] r;
    case (op)
      CMD_LSL: r = SH_LSL;
      CMD_LSR: r = SH_LSR;
      CMD_ASR: r = SH_ASR;
      default: r = SH_NOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shifter.sv
// Registered W-bit shifter: NOP holds, LOAD captures d_in, LSL/LSR/ASR shift by shamt.
module shifter
  import shift_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SH_OP_W-1:0] op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [W-1:0]       d_in,
  output logic [W-1:0]       d_out
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q <= '0;
    end else begin
      case (op)
        SH_LOAD: d_q <= d_in;
        SH_LSL:  d_q <= d_q << shamt;
        SH_LSR:  d_q <= d_q >> shamt;
        SH_ASR:  d_q <= W'($signed(d_q) >>> shamt);
        default: d_q <= d_q;
      endcase
    end
  end

  assign d_out = d_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command front-end for the registered shifter: loads the operand, then splits the
// shift amount into steps of at most MAX_STEP, and returns the result on a handshake.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned W        = DATA_W,
  parameter int unsigned MAX_STEP = SH_MAX_STEP
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CMD_OP_W-1:0] cmd_op,
  input  logic [AMT_W-1:0]    cmd_amt,
  input  logic [W-1:0]        cmd_data,
  output logic [SH_OP_W-1:0]  sh_op,
  output logic [SHAMT_W-1:0]  sh_shamt,
  output logic [W-1:0]        sh_d_in,
  input  logic [W-1:0]        sh_d_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [CMD_OP_W-1:0] op_q, op_d;
  logic [AMT_W-1:0]    amt_q, amt_d;
  logic [W-1:0]        data_q, data_d;
  logic                err_q, err_d;
  logic [AMT_W-1:0]    step;
  logic                ready_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      amt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign step = (amt_q > AMT_W'(MAX_STEP)) ? AMT_W'(MAX_STEP) : amt_q;

  // Next state and outputs; cmd_* only feeds the latch path, never sh_*
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    amt_d     = amt_q;
    data_d    = data_q;
    err_d     = err_q;
    ready_c   = 1'b0;
    sh_op     = SH_NOP;
    sh_shamt  = '0;
    sh_d_in   = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
      end
      S_LOAD: begin
        sh_op   = SH_LOAD;
        sh_d_in = data_q;
        state_d = (amt_q == '0) ? S_RESP : S_SHIFT;
      end
      S_SHIFT: begin
        sh_op    = map_op(op_q);
        sh_shamt = SHAMT_W'(step);
        amt_d    = amt_q - step;
        if (amt_q <= AMT_W'(MAX_STEP)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = sh_d_out;
        rsp_err   = err_q;
        if (rsp_ready) begin
          ready_c = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accept: a reserved op is carried as a zero-amount load flagged as error
    if (ready_c && cmd_valid) begin
      state_d = S_LOAD;
      op_d    = cmd_op;
      data_d  = cmd_data;
      err_d   = (cmd_op == CMD_RSV);
      amt_d   = (cmd_op == CMD_RSV) ? '0 : cmd_amt;
    end
  end

  assign cmd_ready = ready_c & reset_n;
  assign busy      = (state_q != S_IDLE);

endmodule
